// File: rtl/press_pkg.sv
// Shared types and default sizing for the press arbiter.
package press_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    FIRE = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int PRESS_N     = 4;
  localparam int PRESS_QUAL  = 6;
  localparam int PRESS_CNT_W = 10;

endpackage

// File: rtl/press_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
module press_rr_pick #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] idx
);

  int j;

  // Walk from farthest to nearest so the nearest hit is written last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        any = 1'b1;
        idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/press_arbiter.sv
// Shared press qualifier: round-robin grant, tick counting,
// one-cycle tagged press pulse, then wait for release.
module press_arbiter
  import press_pkg::*;
#(
  parameter  int N          = PRESS_N,
  parameter  int QUAL_COUNT = PRESS_QUAL,
  parameter  int CNT_W      = PRESS_CNT_W,
  localparam int PW         = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic [N-1:0]  btn,
  output logic          pressed,
  output logic [PW-1:0] pressed_id,
  output logic [N-1:0]  grant,
  output logic          busy
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [PW-1:0]    ptr, ptr_nx;
  logic [PW-1:0]    gid, gid_nx, gid_inc;
  logic             pick_any;
  logic [PW-1:0]    pick_idx;
  logic             held, last;

  logic             pressed_nx;
  logic [PW-1:0]    pressed_id_nx;
  logic [N-1:0]     grant_nx;
  logic             busy_nx;

  assign held    = btn[gid];
  assign last    = (cnt == CNT_W'(QUAL_COUNT - 1));
  assign gid_inc = (gid == PW'(N - 1)) ? '0 : gid + PW'(1);

  press_rr_pick #(.N(N)) u_pick (
    .req (btn),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      gid        <= '0;
      pressed    <= 1'b0;
      pressed_id <= '0;
      grant      <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      ptr        <= ptr_nx;
      gid        <= gid_nx;
      pressed    <= pressed_nx;
      pressed_id <= pressed_id_nx;
      grant      <= grant_nx;
      busy       <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    gid_nx   = gid;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          gid_nx   = pick_idx;
          cnt_nx   = '0;
          state_nx = QUAL;
        end
      end
      QUAL: begin
        // Release outranks a coincident tick.
        if (!held) begin
          state_nx = IDLE;
          ptr_nx   = gid_inc;
        end else if (tick && last) begin
          state_nx = FIRE;
        end else if (tick) begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      FIRE: begin
        ptr_nx   = gid_inc;
        state_nx = held ? HOLD : IDLE;
      end
      HOLD: begin
        if (!held) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state.
  always_comb begin
    busy_nx       = (state_nx != IDLE);
    pressed_nx    = (state_nx == FIRE);
    pressed_id_nx = pressed_nx ? gid_nx : pressed_id;
    grant_nx      = '0;
    if (busy_nx) grant_nx[gid_nx] = 1'b1;
  end

endmodule

// File: tb/tb_press_arbiter.sv
// Directed bench for press_arbiter: defaults instance plus
// a QUAL_COUNT=1 instance for the minimum-count case.
module tb_press_arbiter;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       tick  = 1'b0;
  logic       tick1 = 1'b0;
  logic [3:0] btn   = 4'b0;
  logic [3:0] btn1  = 4'b0;

  logic       pressed, pressed1;
  logic       busy, busy1;
  logic [1:0] pressed_id, pressed_id1;
  logic [3:0] grant, grant1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  press_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .btn        (btn),
    .pressed    (pressed),
    .pressed_id (pressed_id),
    .grant      (grant),
    .busy       (busy)
  );

  press_arbiter #(
    .N          (4),
    .QUAL_COUNT (1),
    .CNT_W      (10)
  ) dut1 (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick1),
    .btn        (btn1),
    .pressed    (pressed1),
    .pressed_id (pressed_id1),
    .grant      (grant1),
    .busy       (busy1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    btn   = '0;
    tick  = 1'b0;
    cyc();
    cyc();
    tests++;
    if ({pressed, busy, grant, pressed_id} !== 8'b0) begin
      fails++;
      $display("FAIL reset_vals: p=%b b=%b g=%b id=%0d want 0",
               pressed, busy, grant, pressed_id);
    end
    reset = 1'b1;
    cyc();
    tests++;
    if (busy !== 1'b0 || grant !== 4'b0) begin
      fails++;
      $display("FAIL idle_after_reset: b=%b g=%b want 0 0",
               busy, grant);
    end
  endtask

  task automatic test_reset_mid_qual();
    btn  = 4'b0001;
    tick = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      if (c == 1) begin
        tests++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
          fails++;
          $display("FAIL qual_entry: g=%b b=%b want 0001 1",
                   grant, busy);
        end
      end
      tests++;
      if (pressed !== 1'b0) begin
        fails++;
        $display("FAIL early_pulse c%0d: p=%b want 0", c, pressed);
      end
    end
    reset = 1'b0;
    #1;
    tests++;
    if ({pressed, busy, grant, pressed_id} !== 8'b0) begin
      fails++;
      $display("FAIL async_reset: p=%b b=%b g=%b want 0",
               pressed, busy, grant);
    end
    cyc();
    cyc();
    tests++;
    if (pressed !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL in_reset: p=%b b=%b want 0 0", pressed, busy);
    end
    reset = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      tests++;
      if (pressed !== (c == 7)) begin
        fails++;
        $display("FAIL pulse_timing c%0d: p=%b want %b",
                 c, pressed, (c == 7));
      end
      if (c == 7) begin
        tests++;
        if (pressed_id !== 2'd0) begin
          fails++;
          $display("FAIL pulse_id: id=%0d want 0", pressed_id);
        end
      end
    end
    btn = 4'b0;
    cyc();
    cyc();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL release_idle: b=%b want 0", busy);
    end
  endtask

  task automatic test_abandon();
    btn  = 4'b0010;
    tick = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      tests++;
      if (pressed !== 1'b0) begin
        fails++;
        $display("FAIL abandon_pulse c%0d: p=%b want 0", c, pressed);
      end
      if (c == 1) begin
        tests++;
        if (grant !== 4'b0010) begin
          fails++;
          $display("FAIL abandon_grant: g=%b want 0010", grant);
        end
      end
      tick = (c % 3 == 2);
      if (c == 12) btn = 4'b0;
    end
    cyc();
    tests++;
    if (busy !== 1'b0 || grant !== 4'b0 || pressed !== 1'b0) begin
      fails++;
      $display("FAIL abandon_idle: b=%b g=%b p=%b want 0 0000 0",
               busy, grant, pressed);
    end
    btn = 4'b0110;
    cyc();
    tests++;
    if (grant !== 4'b0100) begin
      fails++;
      $display("FAIL abandon_ptr: g=%b want 0100", grant);
    end
    btn = 4'b0;
    cyc();
    cyc();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [5];
    int         k;
    int         phase;
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    k      = 0;
    phase  = 0;
    reset  = 1'b0;
    cyc();
    reset  = 1'b1;
    btn    = 4'b1111;
    tick   = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      cyc();
      if (pressed) begin
        tests++;
        if (pressed_id !== exp_id[k]) begin
          fails++;
          $display("FAIL rr_seq[%0d]: id=%0d want %0d",
                   k, pressed_id, exp_id[k]);
        end
        k++;
        phase = 1;
        if (k == 5) break;
      end else if (phase == 1) begin
        btn   = 4'b0;
        phase = 2;
      end else if (phase == 2) begin
        btn   = 4'b1111;
        phase = 0;
      end
    end
    tests++;
    if (k != 5) begin
      fails++;
      $display("FAIL rr_count: pulses=%0d want 5", k);
    end
    btn = 4'b0;
    cyc();
    cyc();
    cyc();
  endtask

  task automatic test_hold_block();
    int fires;
    fires = 0;
    btn   = 4'b0001;
    tick  = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      if (pressed) begin
        fires++;
        tests++;
        if (pressed_id !== 2'd0) begin
          fails++;
          $display("FAIL hold_id: id=%0d want 0", pressed_id);
        end
      end
      if (c == 30) begin
        tests++;
        if (busy !== 1'b1 || grant !== 4'b0001) begin
          fails++;
          $display("FAIL hold_owner: b=%b g=%b want 1 0001",
                   busy, grant);
        end
      end
      if (c == 10) btn = 4'b0101;
      if (c == 20) btn = 4'b0001;
    end
    tests++;
    if (fires != 1) begin
      fails++;
      $display("FAIL hold_fires: got %0d want 1", fires);
    end
    btn = 4'b0;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      tests++;
      if (pressed !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL hold_after c%0d: p=%b b=%b want 0 0",
                 c, pressed, busy);
      end
    end
  endtask

  task automatic test_collision();
    btn  = 4'b0001;
    tick = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      tests++;
      if (pressed !== 1'b0) begin
        fails++;
        $display("FAIL coll_early c%0d: p=%b want 0", c, pressed);
      end
    end
    tests++;
    if (busy !== 1'b1 || grant !== 4'b0001) begin
      fails++;
      $display("FAIL coll_qual: b=%b g=%b want 1 0001", busy, grant);
    end
    btn = 4'b0;
    cyc();
    tests++;
    if (pressed !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL coll_release: p=%b b=%b want 0 0",
               pressed, busy);
    end
    cyc();
    tests++;
    if (pressed !== 1'b0) begin
      fails++;
      $display("FAIL coll_late: p=%b want 0", pressed);
    end
    tick = 1'b0;
  endtask

  task automatic test_min_count();
    btn1  = 4'b0100;
    tick1 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      if (c == 1) begin
        tests++;
        if (grant1 !== 4'b0100) begin
          fails++;
          $display("FAIL min_grant: g=%b want 0100", grant1);
        end
      end
      tests++;
      if (pressed1 !== (c == 2)) begin
        fails++;
        $display("FAIL min_pulse c%0d: p=%b want %b",
                 c, pressed1, (c == 2));
      end
      if (c == 2) begin
        tests++;
        if (pressed_id1 !== 2'd2) begin
          fails++;
          $display("FAIL min_id: id=%0d want 2", pressed_id1);
        end
      end
    end
    btn1  = 4'b0;
    tick1 = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_reset_mid_qual();
    test_abandon();
    test_round_robin();
    test_hold_block();
    test_collision();
    test_min_count();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
